// File: rtl/text_cell_renderer.sv
// text_cell_renderer
//   Text-mode pixel generator. For each 8-pixel cell it fetches the character
//   code and attribute from screen RAM, then the glyph row from glyph ROM. The
//   glyph row is shifted out LSB-first as 12-bit RGB, 8 clocks after the beam
//   position was sampled.
//
// Ports
//   clk, rst                  pixel clock, synchronous active-high reset
//   posx, posy, active        beam position and display enable
//   frame_start               one-cycle pulse per frame (blink timebase)
//   blink_mode                0: attr[3] is bg intensity, 1: attr[3] is blink
//   cursor_en/_x/_y           underline cursor enable and cell position
//   scr_addr / scr_val        screen RAM address/data (1-cycle read latency)
//   chr_sub_addr / chr_sub    glyph ROM address/data (1-cycle read latency)
//   r_pixel/g_pixel/b_pixel   4-bit colour channels
//   pix_valid                 active delayed by 8 clocks
module text_cell_renderer #(
  parameter int CHAR_H       = 16,
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int GLYPH_BASE   = 32,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  posx,
  input  logic [8:0]  posy,
  input  logic        active,
  input  logic        frame_start,
  input  logic        blink_mode,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  output logic [15:0] scr_addr,
  input  logic [7:0]  scr_val,
  output logic [11:0] chr_sub_addr,
  input  logic [7:0]  chr_sub,
  output logic [3:0]  r_pixel,
  output logic [3:0]  g_pixel,
  output logic [3:0]  b_pixel,
  output logic        pix_valid
);

  localparam int GLOG = $clog2(CHAR_H);
  localparam int RW   = 9 - GLOG;
  localparam int FCW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  if (2 * COLS * ROWS > 65536) begin : g_bad_geometry
    $error("text_cell_renderer: screen of %0d x %0d cells exceeds 64 KiB screen RAM", COLS, ROWS);
  end

  typedef enum logic [2:0] {
    FETCH_CHR,
    FETCH_ATTR,
    FETCH_GLYPH,
    CAPTURE,
    WAIT
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     wait_q, wait_d;
  logic [RW-1:0]  row_q, row_d;
  logic [GLOG-1:0] grow_q, grow_d;
  logic           oor_q, oor_d;
  logic           curs_q, curs_d;
  logic           bm_q, bm_d;
  logic [7:0]     code_q, code_d;
  logic [7:0]     attr_q, attr_d;
  logic [15:0]    scr_addr_q, scr_addr_d;
  logic [11:0]    chr_addr_q, chr_addr_d;

  // Fetched cell waiting for the next k=0 load.
  logic [7:0]     pend_glyph_q, pend_glyph_d;
  logic [7:0]     pend_attr_q, pend_attr_d;
  logic           pend_bm_q, pend_bm_d;
  logic           pend_oor_q, pend_oor_d;
  logic           pend_valid_q, pend_valid_d;

  // Cell currently being serialised.
  logic [7:0]     sh_q, sh_d;
  logic [7:0]     dattr_q, dattr_d;
  logic           dbm_q, dbm_d;
  logic           door_q, door_d;
  logic           dvalid_q, dvalid_d;
  logic [2:0]     dcnt_q, dcnt_d;

  logic [7:0]     act_dly_q, act_dly_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           phase_q, phase_d;

  logic [3:0]     r_q, r_d, g_q, g_d, b_q, b_d;
  logic           pv_q, pv_d;

  function automatic logic [3:0] chan(input logic c, input logic i);
    return {c, (c & i) ? 3'b111 : 3'b000};
  endfunction

  logic [6:0]     col_in;
  logic [RW-1:0]  row_in;
  logic [GLOG-1:0] grow_in;
  logic [15:0]    idx_w;
  logic [11:0]    glyph_off;
  logic [7:0]     glyph_mod;
  logic           load;
  logic           pix_bit, pix_bm, pix_oor, slot_ok, bg_i;
  logic [7:0]     pix_attr;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    row_d        = row_q;
    grow_d       = grow_q;
    oor_d        = oor_q;
    curs_d       = curs_q;
    bm_d         = bm_q;
    code_d       = code_q;
    attr_d       = attr_q;
    scr_addr_d   = scr_addr_q;
    chr_addr_d   = chr_addr_q;
    pend_glyph_d = pend_glyph_q;
    pend_attr_d  = pend_attr_q;
    pend_bm_d    = pend_bm_q;
    pend_oor_d   = pend_oor_q;
    pend_valid_d = pend_valid_q;
    sh_d         = sh_q;
    dattr_d      = dattr_q;
    dbm_d        = dbm_q;
    door_d       = door_q;
    dvalid_d     = dvalid_q;
    dcnt_d       = dcnt_q;
    fcnt_d       = fcnt_q;
    phase_d      = phase_q;
    act_dly_d    = {act_dly_q[6:0], active};

    col_in    = posx[9:3];
    row_in    = posy[8:GLOG];
    grow_in   = posy[GLOG-1:0];
    idx_w     = 16'(row_in) * 16'(COLS) + 16'(col_in);
    glyph_off = 12'({4'b0000, scr_val} - 12'(GLYPH_BASE));
    glyph_mod = chr_sub;
    if (32'(code_q) < GLYPH_BASE) glyph_mod = 8'h00;
    if (curs_q && !phase_q && (32'(grow_q) >= CHAR_H - 2)) glyph_mod = 8'hFF;
    if (bm_q && attr_q[3] && phase_q) glyph_mod = 8'h00;

    // Display stage: the pending cell is loaded at every k=0 edge. The first
    // pixel comes straight from the pending glyph, the rest from the shifter.
    load = (posx[2:0] == 3'd0);
    if (load) begin
      pix_bit      = pend_glyph_q[0];
      pix_attr     = pend_attr_q;
      pix_bm       = pend_bm_q;
      pix_oor      = pend_oor_q;
      slot_ok      = pend_valid_q;
      sh_d         = {1'b0, pend_glyph_q[7:1]};
      dattr_d      = pend_attr_q;
      dbm_d        = pend_bm_q;
      door_d       = pend_oor_q;
      dvalid_d     = pend_valid_q;
      dcnt_d       = 3'd7;
      pend_valid_d = 1'b0;
    end else begin
      pix_bit  = sh_q[0];
      pix_attr = dattr_q;
      pix_bm   = dbm_q;
      pix_oor  = door_q;
      slot_ok  = dvalid_q && (dcnt_q != 3'd0);
      sh_d     = {1'b0, sh_q[7:1]};
      if (dcnt_q != 3'd0) dcnt_d = dcnt_q - 3'd1;
    end

    bg_i = pix_attr[3] & ~pix_bm;
    pv_d = slot_ok && act_dly_q[7];
    r_d  = 4'h0;
    g_d  = 4'h0;
    b_d  = 4'h0;
    if (pv_d && !pix_oor) begin
      if (pix_bit) begin
        r_d = chan(pix_attr[6], pix_attr[7]);
        g_d = chan(pix_attr[5], pix_attr[7]);
        b_d = chan(pix_attr[4], pix_attr[7]);
      end else begin
        r_d = chan(pix_attr[2], bg_i);
        g_d = chan(pix_attr[1], bg_i);
        b_d = chan(pix_attr[0], bg_i);
      end
    end

    // Fetch sequence; runs from the state sequence once started at k=0.
    case (state_q)
      FETCH_CHR: begin
        if (active && (posx[2:0] == 3'd0)) begin
          row_d      = row_in;
          grow_d     = grow_in;
          oor_d      = (32'(col_in) >= COLS) || (32'(row_in) >= ROWS);
          curs_d     = cursor_en && (col_in == cursor_x) && (32'(row_in) == 32'(cursor_y));
          bm_d       = blink_mode;
          scr_addr_d = {idx_w[14:0], 1'b0};
          state_d    = FETCH_ATTR;
        end
      end
      FETCH_ATTR: begin
        scr_addr_d = {scr_addr_q[15:1], 1'b1};
        state_d    = FETCH_GLYPH;
      end
      FETCH_GLYPH: begin
        code_d     = scr_val;
        chr_addr_d = 12'(glyph_off << GLOG) + 12'(grow_q);
        state_d    = CAPTURE;
      end
      CAPTURE: begin
        attr_d  = scr_val;
        wait_d  = 2'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == 2'd0) begin
          pend_glyph_d = glyph_mod;
          pend_attr_d  = attr_q;
          pend_bm_d    = bm_q;
          pend_oor_d   = oor_q;
          pend_valid_d = 1'b1;
        end
        wait_d = wait_q + 2'd1;
        if (wait_q == 2'd3) state_d = FETCH_CHR;
      end
      default: state_d = FETCH_CHR;
    endcase

    if (frame_start) begin
      if (32'(fcnt_q) == BLINK_FRAMES - 1) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_CHR;
      wait_q       <= '0;
      row_q        <= '0;
      grow_q       <= '0;
      oor_q        <= 1'b0;
      curs_q       <= 1'b0;
      bm_q         <= 1'b0;
      code_q       <= '0;
      attr_q       <= '0;
      scr_addr_q   <= '0;
      chr_addr_q   <= '0;
      pend_glyph_q <= '0;
      pend_attr_q  <= '0;
      pend_bm_q    <= 1'b0;
      pend_oor_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      sh_q         <= '0;
      dattr_q      <= '0;
      dbm_q        <= 1'b0;
      door_q       <= 1'b0;
      dvalid_q     <= 1'b0;
      dcnt_q       <= '0;
      act_dly_q    <= '0;
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      pv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      row_q        <= row_d;
      grow_q       <= grow_d;
      oor_q        <= oor_d;
      curs_q       <= curs_d;
      bm_q         <= bm_d;
      code_q       <= code_d;
      attr_q       <= attr_d;
      scr_addr_q   <= scr_addr_d;
      chr_addr_q   <= chr_addr_d;
      pend_glyph_q <= pend_glyph_d;
      pend_attr_q  <= pend_attr_d;
      pend_bm_q    <= pend_bm_d;
      pend_oor_q   <= pend_oor_d;
      pend_valid_q <= pend_valid_d;
      sh_q         <= sh_d;
      dattr_q      <= dattr_d;
      dbm_q        <= dbm_d;
      door_q       <= door_d;
      dvalid_q     <= dvalid_d;
      dcnt_q       <= dcnt_d;
      act_dly_q    <= act_dly_d;
      fcnt_q       <= fcnt_d;
      phase_q      <= phase_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      pv_q         <= pv_d;
    end
  end

  assign scr_addr     = scr_addr_q;
  assign chr_sub_addr = chr_addr_q;
  assign r_pixel      = r_q;
  assign g_pixel      = g_q;
  assign b_pixel      = b_q;
  assign pix_valid    = pv_q;

endmodule

// File: tb/tb_text_cell_renderer.sv
// tb_text_cell_renderer
//   Directed bench for text_cell_renderer (CHAR_H=16, 80x30, BLINK_FRAMES=2).
//   Screen RAM and glyph ROM are modelled as 1-cycle-latency memories; outputs
//   are recorded 1 ns after every rising edge and checked against hand-computed
//   colours. Output recorded at cycle n+8 is the pixel sampled at edge n.
module tb_text_cell_renderer;

  localparam int CH = 16;
  localparam int NC = 80;
  localparam int NR = 30;
  localparam int GB = 32;
  localparam int BF = 2;
  localparam int NREC = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  posx;
  logic [8:0]  posy;
  logic        active;
  logic        frame_start;
  logic        blink_mode;
  logic        cursor_en;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [15:0] scr_addr;
  logic [7:0]  scr_val;
  logic [11:0] chr_sub_addr;
  logic [7:0]  chr_sub;
  logic [3:0]  r_pixel, g_pixel, b_pixel;
  logic        pix_valid;

  text_cell_renderer #(
    .CHAR_H(CH), .COLS(NC), .ROWS(NR), .GLYPH_BASE(GB), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .posx(posx), .posy(posy), .active(active),
    .frame_start(frame_start), .blink_mode(blink_mode), .cursor_en(cursor_en),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .scr_addr(scr_addr),
    .scr_val(scr_val), .chr_sub_addr(chr_sub_addr), .chr_sub(chr_sub),
    .r_pixel(r_pixel), .g_pixel(g_pixel), .b_pixel(b_pixel),
    .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  logic [7:0] scr_mem [0:65535];
  logic [7:0] glyph_mem [0:4095];

  always @(posedge clk) begin
    scr_val <= scr_mem[scr_addr];
    chr_sub <= glyph_mem[chr_sub_addr];
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc = 0;
  logic [11:0] o_rgb [0:NREC-1];
  logic        o_v   [0:NREC-1];
  logic [15:0] o_scr [0:NREC-1];
  logic [11:0] o_chr [0:NREC-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cyc < NREC - 1) cyc++;
    o_rgb[cyc] = {r_pixel, g_pixel, b_pixel};
    o_v[cyc]   = pix_valid;
    o_scr[cyc] = scr_addr;
    o_chr[cyc] = chr_sub_addr;
  endtask

  task automatic drive(input int px, input int py, input logic act);
    posx   = 10'(px);
    posy   = 9'(py);
    active = act;
    tick();
  endtask

  // n cycles with the given enable from x0, then 16 idle cycles to drain.
  // n0 is the edge that sampled x0.
  task automatic run(input int x0, input int y, input int n, input logic act, output int n0);
    n0 = 0;
    for (int i = 0; i < n; i++) begin
      drive(x0 + i, y, act);
      if (i == 0) n0 = cyc;
    end
    for (int i = 0; i < 16; i++) drive(x0 + n + i, y, 1'b0);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    drive(0, 0, 1'b0);
    frame_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    for (int i = 0; i < 65536; i++) scr_mem[i] = 8'h00;
    for (int i = 0; i < 4096; i++) glyph_mem[i] = 8'h00;
    scr_mem[164] = 8'h41; scr_mem[165] = 8'h1E;    // (2,1)
    scr_mem[166] = 8'h07; scr_mem[167] = 8'h1E;    // (3,1) control code
    scr_mem[168] = 8'h41; scr_mem[169] = 8'h8F;    // (4,1) blink
    scr_mem[170] = 8'h41; scr_mem[171] = 8'h1E;    // (5,1)
    scr_mem[172] = 8'h41; scr_mem[173] = 8'h1E;    // (6,1)
    scr_mem[160] = 8'h41; scr_mem[161] = 8'h1E;    // (0,1)
    scr_mem[320] = 8'h41; scr_mem[321] = 8'h1E;    // aliased by col 80 row 1
    scr_mem[490] = 8'h41; scr_mem[491] = 8'h1E;    // (5,3) cursor cell
    scr_mem[4800] = 8'h41; scr_mem[4801] = 8'h1E;  // row 30 col 0
    glyph_mem[533]  = 8'h81;
    glyph_mem[542]  = 8'h81;
    glyph_mem[543]  = 8'h81;
    glyph_mem[528]  = 8'hFF;
    glyph_mem[3701] = 8'hFF;                       // (0x07-32)*16+5 mod 4096

    frame_start = 1'b0; blink_mode = 1'b0; cursor_en = 1'b0;
    cursor_x = 7'd5; cursor_y = 5'd3;
    posx = '0; posy = '0; active = 1'b0;

    // Reset held 3 clocks with active=1, released mid-cell.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i, 0, 1'b1);
      check_eq("rst_rgb", 32'(o_rgb[cyc]), 32'h0);
      check_eq("rst_valid", 32'(o_v[cyc]), 32'h0);
      check_eq("rst_scr_addr", 32'(o_scr[cyc]), 32'h0);
      check_eq("rst_chr_addr", 32'(o_chr[cyc]), 32'h0);
    end
    rst = 1'b0;
    for (int x = 3; x < 8; x++) drive(x, 0, 1'b1);
    run(8, 0, 8, 1'b1, n0);
    check_eq("rst_unaligned_valid", 32'(o_v[n0 + 3]), 32'h0);
    check_eq("rst_first_valid_m1", 32'(o_v[n0 + 7]), 32'h0);
    check_eq("rst_first_valid", 32'(o_v[n0 + 8]), 32'h1);
    check_eq("rst_first_rgb", 32'(o_rgb[n0 + 8]), 32'h000);

    // 'A' attr 0x1E at (2,1), posy 21: glyph 0x81 -> fg at pixels 0 and 7.
    run(16, 21, 8, 1'b1, n0);
    check_eq("a_scr_chr", 32'(o_scr[n0]), 32'd164);
    check_eq("a_scr_attr", 32'(o_scr[n0 + 1]), 32'd165);
    check_eq("a_glyph_addr", 32'(o_chr[n0 + 2]), 32'd533);
    for (int i = 0; i < 8; i++) begin
      check_eq("a_rgb", 32'(o_rgb[n0 + 8 + i]), (i == 0 || i == 7) ? 32'h008 : 32'hFF0);
      check_eq("a_valid", 32'(o_v[n0 + 8 + i]), 32'h1);
    end
    check_eq("a_after_valid", 32'(o_v[n0 + 16]), 32'h0);

    // Control code 0x07: blank glyph despite ROM content 0xFF.
    run(24, 21, 8, 1'b1, n0);
    check_eq("ctl_glyph_addr", 32'(o_chr[n0 + 2]), 32'd3701);
    for (int i = 0; i < 8; i += 3)
      check_eq("ctl_rgb", 32'(o_rgb[n0 + 8 + i]), 32'hFF0);

    // Blink attribute 0x8F: fg black shown in frames 0-1, hidden in 2-3.
    blink_mode = 1'b1;
    for (int f = 0; f < 4; f++) begin
      run(32, 21, 8, 1'b1, n0);
      check_eq("blink_px0", 32'(o_rgb[n0 + 8]), (f < 2) ? 32'h000 : 32'h888);
      check_eq("blink_px1", 32'(o_rgb[n0 + 9]), 32'h888);
      check_eq("blink_px7", 32'(o_rgb[n0 + 15]), (f < 2) ? 32'h000 : 32'h888);
      if (f < 3) pulse_frame();
    end
    blink_mode = 1'b0;

    // Cursor at (5,3); blink phase currently 1 -> underline hidden.
    cursor_en = 1'b1;
    run(40, 62, 8, 1'b1, n0);
    check_eq("cur_off_px0", 32'(o_rgb[n0 + 8]), 32'h008);
    check_eq("cur_off_px1", 32'(o_rgb[n0 + 9]), 32'hFF0);
    pulse_frame();
    run(40, 62, 8, 1'b1, n0);
    check_eq("cur_g14_px1", 32'(o_rgb[n0 + 9]), 32'h008);
    check_eq("cur_g14_px3", 32'(o_rgb[n0 + 11]), 32'h008);
    run(40, 63, 8, 1'b1, n0);
    check_eq("cur_g15_px1", 32'(o_rgb[n0 + 9]), 32'h008);
    run(40, 53, 8, 1'b1, n0);
    check_eq("cur_g5_px1", 32'(o_rgb[n0 + 9]), 32'hFF0);
    check_eq("cur_g5_px0", 32'(o_rgb[n0 + 8]), 32'h008);
    cursor_en = 1'b0;
    run(40, 63, 8, 1'b1, n0);
    check_eq("cur_dis_px1", 32'(o_rgb[n0 + 9]), 32'hFF0);

    // Column 80 and row 30 are outside the screen: black but valid.
    run(640, 21, 8, 1'b1, n0);
    check_eq("col80_rgb0", 32'(o_rgb[n0 + 8]), 32'h000);
    check_eq("col80_rgb1", 32'(o_rgb[n0 + 9]), 32'h000);
    check_eq("col80_valid", 32'(o_v[n0 + 8]), 32'h1);
    run(0, 480, 8, 1'b1, n0);
    check_eq("row30_rgb", 32'(o_rgb[n0 + 9]), 32'h000);
    check_eq("row30_valid", 32'(o_v[n0 + 9]), 32'h1);

    // active=0 over a populated cell.
    run(8, 21, 8, 1'b0, n0);
    check_eq("inact_valid", 32'(o_v[n0 + 8]), 32'h0);
    check_eq("inact_rgb", 32'(o_rgb[n0 + 8]), 32'h000);

    // Entered at k=3: cell (5,1) is skipped, cell (6,1) renders normally.
    run(43, 21, 13, 1'b1, n0);
    check_eq("unal_valid", 32'(o_v[n0 + 9]), 32'h0);
    check_eq("unal_rgb", 32'(o_rgb[n0 + 10]), 32'h000);
    check_eq("unal_next_valid", 32'(o_v[n0 + 13]), 32'h1);
    check_eq("unal_next_rgb0", 32'(o_rgb[n0 + 13]), 32'h008);
    check_eq("unal_next_rgb1", 32'(o_rgb[n0 + 14]), 32'hFF0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
